uart_tx_arbiter: RTL

Message-level arbiter sharing the single UART TX FIFO write port among several byte producers (AT-command setup flow, data streamer, debug console). A requester is granted the FIFO for a whole message, CR LF terminated, so bytes from different producers never interleave on the BLE link. The arbiter forwards the owner's bytes, applies TX FIFO backpressure per requester, and revokes a stalled owner after a timeout.

---
 rtl/uart_tx_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Message-level arbiter that shares the UART TX FIFO write port among byte producers.
// A grant lasts for a whole CR LF terminated message; stalled owners are revoked on timeout.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int PRIO_MODE    = 0,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   byte_ready,
    input  logic [8*NUM_REQ-1:0] cmd_byte,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   req_full,
    output logic [1:0]           owner,
    input  logic                 tx_full,
    output logic                 tx_wr_en,
    output logic [7:0]           tx_data,
    output logic                 timeout_err,
    output logic                 drop_err
);

    localparam int TW = $clog2(IDLE_TIMEOUT);
    localparam logic [TW-1:0] TIMER_MAX = TW'(IDLE_TIMEOUT - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t             state_reg, state_next;
    logic [NUM_REQ-1:0] grant_reg, grant_next;
    logic [1:0]         owner_reg, owner_next;
    logic               last_cr_reg, last_cr_next;
    logic [TW-1:0]      timer_reg, timer_next;
    logic               timeout_err_reg, timeout_err_next;
    logic               drop_err_reg, drop_err_next;

    // Pad per-requester vectors to four entries so the 2-bit owner index always fits.
    logic [3:0] req_pad;
    logic [3:0] ready_pad;
    logic [7:0] byte_arr [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pad
            if (gi < NUM_REQ) begin : g_used
                assign req_pad[gi]   = req[gi];
                assign ready_pad[gi] = byte_ready[gi];
                assign byte_arr[gi]  = cmd_byte[8*gi +: 8];
            end else begin : g_unused
                assign req_pad[gi]   = 1'b0;
                assign ready_pad[gi] = 1'b0;
                assign byte_arr[gi]  = 8'h00;
            end
        end
    endgenerate

    logic       accept;
    logic [7:0] cur_byte;
    logic       lf_done;
    logic       expire;
    logic       owner_req;

    assign cur_byte  = byte_arr[owner_reg];
    assign owner_req = req_pad[owner_reg];
    assign accept    = (state_reg == OWN) && ready_pad[owner_reg] && !tx_full;
    assign lf_done   = accept && (cur_byte == 8'h0A) && last_cr_reg;
    // An accepted byte in the expiry cycle wins; backpressure never expires the owner.
    assign expire    = (state_reg == OWN) && !accept && !tx_full && (timer_reg == TIMER_MAX);

    logic [1:0] win_idx;
    logic [1:0] rr_idx;
    logic       win_found;

    always_comb begin
        win_idx   = owner_reg;
        rr_idx    = 2'd0;
        win_found = 1'b0;
        if (PRIO_MODE == 1) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!win_found && req_pad[k]) begin
                    win_idx   = 2'(k);
                    win_found = 1'b1;
                end
            end
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                rr_idx = 2'((int'(owner_reg) + k) % NUM_REQ);
                if (!win_found && req_pad[rr_idx]) begin
                    win_idx   = rr_idx;
                    win_found = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            grant_reg       <= '0;
            owner_reg       <= 2'd0;
            last_cr_reg     <= 1'b0;
            timer_reg       <= '0;
            timeout_err_reg <= 1'b0;
            drop_err_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            grant_reg       <= grant_next;
            owner_reg       <= owner_next;
            last_cr_reg     <= last_cr_next;
            timer_reg       <= timer_next;
            timeout_err_reg <= timeout_err_next;
            drop_err_reg    <= drop_err_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        grant_next       = grant_reg;
        owner_next       = owner_reg;
        last_cr_next     = last_cr_reg;
        timer_next       = timer_reg;
        timeout_err_next = 1'b0;
        drop_err_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                drop_err_next = |byte_ready;
                if (win_found) begin
                    for (int k = 0; k < NUM_REQ; k++) begin
                        grant_next[k] = (win_idx == 2'(k));
                    end
                    owner_next   = win_idx;
                    last_cr_next = 1'b0;
                    timer_next   = '0;
                    state_next   = OWN;
                end
            end
            OWN: begin
                drop_err_next = (|(byte_ready & ~grant_reg)) || (ready_pad[owner_reg] && tx_full);
                if (accept) begin
                    timer_next   = '0;
                    last_cr_next = (cur_byte == 8'h0D);
                end else if (!tx_full) begin
                    timer_next = timer_reg + 1'b1;
                end
                if (lf_done || !owner_req || expire) begin
                    state_next       = IDLE;
                    grant_next       = '0;
                    timer_next       = '0;
                    timeout_err_next = expire && owner_req;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    assign grant       = grant_reg;
    assign owner       = owner_reg;
    assign req_full    = ~(grant_reg & {NUM_REQ{~tx_full}});
    assign tx_wr_en    = accept;
    assign tx_data     = (state_reg == OWN) ? cur_byte : 8'h00;
    assign timeout_err = timeout_err_reg;
    assign drop_err    = drop_err_reg;

endmodule
